// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
//   - state encodings (also exported on state_dbg)
//   - opcode constants for the IR[31:26] field
//   - ALUOp / ALUSrcB / PCSource encodings
//   - the control word produced by the output decoder
//   - decode_next(): opcode -> first post-DECODE state
package mc_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int CNT_W   = 32;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_HALT      = 4'd13,
        ST_TRAP      = 4'd14
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [2:0] {
        SRCB_REG     = 3'b000,
        SRCB_FOUR    = 3'b001,
        SRCB_IMM     = 3'b010,
        SRCB_IMM_SH2 = 3'b011
    } srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef struct packed {
        logic   pc_write_cond;
        logic   pc_write;
        logic   i_or_d;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   ir_write;
        pcsrc_e pc_source;
        aluop_e alu_op;
        srcb_e  alu_src_b;
        logic   alu_src_a;
        logic   reg_write;
        logic   reg_dst;
        logic   halted;
        logic   illegal_op;
    } ctrl_word_t;

    // lw and sw share MEM_ADDR; the load/store split is resolved there
    // from a flag captured alongside this decode.
    function automatic state_e decode_next(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE:     return ST_R_EXEC;
            OP_LW, OP_SW: return ST_MEM_ADDR;
            OP_BEQ:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            OP_ADDI:      return ST_ADDI_EXEC;
            OP_HALT:      return ST_HALT;
            default:      return ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle MIPS controller.
//   opCode       datapath -> controller, IR[31:26]
//   PCWriteCond .. RegDst   controller -> datapath strobes and mux selects
//   halted, illegal_op, instr_count, state_dbg   controller -> debug/status
// master: the controller side; slave: the datapath side.
interface multicycle_control_if
    import mc_ctrl_pkg::*;
#(
    parameter int IF_OP_W    = OP_W,
    parameter int IF_CNT_W   = CNT_W,
    parameter int IF_STATE_W = STATE_W
);
    logic [IF_OP_W-1:0]    opCode;
    logic                  PCWriteCond;
    logic                  PCWrite;
    logic                  IorD;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  MemtoReg;
    logic                  IRWrite;
    logic [1:0]            PCSource;
    logic [1:0]            ALUOp;
    logic [2:0]            ALUSrcB;
    logic                  ALUSrcA;
    logic                  RegWrite;
    logic                  RegDst;
    logic                  halted;
    logic                  illegal_op;
    logic [IF_CNT_W-1:0]   instr_count;
    logic [IF_STATE_W-1:0] state_dbg;

    modport master (
        input  opCode,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
               halted, illegal_op, instr_count, state_dbg
    );

    modport slave (
        output opCode,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
               halted, illegal_op, instr_count, state_dbg
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control word decoder (Moore outputs of the main controller).
//   state  in   current controller state
//   ctrl   out  full control word; every field 0 unless the state asserts it
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                // Speculative branch target, consumed by BRANCH if taken.
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_HALT: ctrl.halted     = 1'b1;
            ST_TRAP: ctrl.illegal_op = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   bus    master side of multicycle_control_if (opCode in; strobes,
//          halted, illegal_op, instr_count, state_dbg out)
//
// state     | meaning
// ----------+------------------------------------------------------
// RST       | reset landing state, all outputs 0
// FETCH     | read instruction, load IR, PC <= PC + 4
// DECODE    | sample opCode, compute branch target
// MEM_ADDR  | effective address for lw/sw
// MEM_RD    | data memory read (lw)
// MEM_WB    | memory data -> rt (lw)
// MEM_WR    | data memory write (sw)
// R_EXEC    | ALU op from funct field
// R_WB      | ALU result -> rd
// ADDI_EXEC | A + sign-extended immediate
// ADDI_WB   | ALU result -> rt
// BRANCH    | compare, PC <= target if zero
// JUMP      | PC <= jump target
// HALT      | stopped until reset
// TRAP      | illegal opcode, stopped until reset
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e             state_q, state_d;
    logic               is_store_q, is_store_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    ctrl_word_t         ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RST;
            is_store_q    <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        instr_count_d = instr_count_q;

        if (state_q == ST_FETCH) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end

        case (state_q)
            ST_RST:       state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE: begin
                // opCode is only trusted here; remember lw vs sw for MEM_ADDR.
                state_d    = decode_next(bus.opCode);
                is_store_d = (bus.opCode == OP_SW);
            end
            ST_MEM_ADDR:  state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WR:    state_d = ST_FETCH;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_ADDI_WB:   state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            ST_TRAP:      state_d = ST_TRAP;
            // Unused encoding: restart cleanly through RST.
            default:      state_d = ST_RST;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.halted      = ctrl.halted;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.instr_count = instr_count_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // pcwc pcw iord mrd mwr m2r irw pcsrc[2] aluop[2] srcb[3] srca rw rdst hlt ill
    typedef struct packed {
        logic       pcwc;
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       irw;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic [2:0] srcb;
        logic       srca;
        logic       rw;
        logic       rdst;
        logic       hlt;
        logic       ill;
    } cv_t;

    typedef struct {
        state_e      st;
        cv_t         cv;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          errors  = 0;
    int          checks  = 0;
    logic [31:0] exp_cnt = 32'd0;

    // Hand-written expected control vector per state.
    function automatic cv_t exp_cv(input state_e st);
        cv_t c;
        c = '0;
        case (st)
            ST_FETCH:     begin c.mrd = 1; c.irw = 1; c.srcb = 3'b001; c.pcw = 1; end
            ST_DECODE:    begin c.srcb = 3'b011; end
            ST_MEM_ADDR:  begin c.srca = 1; c.srcb = 3'b010; end
            ST_MEM_RD:    begin c.mrd = 1; c.iord = 1; end
            ST_MEM_WB:    begin c.rw = 1; c.m2r = 1; end
            ST_MEM_WR:    begin c.mwr = 1; c.iord = 1; end
            ST_R_EXEC:    begin c.srca = 1; c.aluop = 2'b10; end
            ST_R_WB:      begin c.rw = 1; c.rdst = 1; end
            ST_ADDI_EXEC: begin c.srca = 1; c.srcb = 3'b010; end
            ST_ADDI_WB:   begin c.rw = 1; end
            ST_BRANCH:    begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            ST_JUMP:      begin c.pcw = 1; c.pcsrc = 2'b10; end
            ST_HALT:      begin c.hlt = 1; end
            ST_TRAP:      begin c.ill = 1; end
            default:      c = '0;
        endcase
        return c;
    endfunction

    function automatic cv_t act_cv();
        cv_t c;
        c.pcwc  = bus.PCWriteCond;
        c.pcw   = bus.PCWrite;
        c.iord  = bus.IorD;
        c.mrd   = bus.MemRead;
        c.mwr   = bus.MemWrite;
        c.m2r   = bus.MemtoReg;
        c.irw   = bus.IRWrite;
        c.pcsrc = bus.PCSource;
        c.aluop = bus.ALUOp;
        c.srcb  = bus.ALUSrcB;
        c.srca  = bus.ALUSrcA;
        c.rw    = bus.RegWrite;
        c.rdst  = bus.RegDst;
        c.hlt   = bus.halted;
        c.ill   = bus.illegal_op;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input state_e st);
        exp_t e;
        e.st  = st;
        e.cv  = exp_cv(st);
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        if (st == ST_FETCH) exp_cnt++;
    endtask

    // Called one time unit after the edge that entered FETCH; returns
    // one time unit after the edge that enters the next state.
    task automatic run_instr(input logic [5:0] op, input int n,
                             input state_e s0, input state_e s1, input state_e s2,
                             input state_e s3 = ST_RST, input state_e s4 = ST_RST);
        state_e s[5];
        s = '{s0, s1, s2, s3, s4};
        bus.opCode = op;
        for (int i = 0; i < n; i++) push(s[i]);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: the controller presents a control word every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({"state_", e.st.name()}, 32'(bus.state_dbg), 32'(e.st));
            check({"ctrl_",  e.st.name()}, 32'(act_cv()),      32'(e.cv));
            check({"count_", e.st.name()}, bus.instr_count,    e.cnt);
        end
    end

    initial begin
        bus.opCode = 6'b000000;

        // Reset held for three cycles.
        repeat (3) push(ST_RST);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        run_instr(OP_LW,    5, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB);
        run_instr(OP_BEQ,   3, ST_FETCH, ST_DECODE, ST_BRANCH);
        run_instr(OP_J,     3, ST_FETCH, ST_DECODE, ST_JUMP);
        run_instr(OP_RTYPE, 4, ST_FETCH, ST_DECODE, ST_R_EXEC, ST_R_WB);
        run_instr(OP_ADDI,  4, ST_FETCH, ST_DECODE, ST_ADDI_EXEC, ST_ADDI_WB);

        // sw interrupted by reset while in MEM_WR.
        run_instr(OP_SW,    3, ST_FETCH, ST_DECODE, ST_MEM_ADDR);
        check("sw_state_memwr", 32'(bus.state_dbg), 32'(ST_MEM_WR));
        check("sw_memwrite_hi", 32'(bus.MemWrite),  32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_memwrite_lo", 32'(bus.MemWrite),  32'd0);
        check("rst_state",       32'(bus.state_dbg), 32'(ST_RST));
        check("rst_count",       bus.instr_count,    32'd0);
        exp_cnt = 32'd0;
        push(ST_RST);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        run_instr(OP_RTYPE, 4, ST_FETCH, ST_DECODE, ST_R_EXEC, ST_R_WB);

        // Halt absorbs for 20 cycles whatever opCode shows.
        run_instr(OP_HALT,  2, ST_FETCH, ST_DECODE, ST_HALT);
        bus.opCode = OP_LW;
        repeat (20) push(ST_HALT);
        repeat (20) @(posedge clk);
        #1;

        reset = 1'b0;
        #1;
        check("halt_rst_halted", 32'(bus.halted), 32'd0);
        exp_cnt = 32'd0;
        push(ST_RST);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // Undefined opcode traps.
        run_instr(6'b010101, 2, ST_FETCH, ST_DECODE, ST_TRAP);
        repeat (3) push(ST_TRAP);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
